// File: rtl/out_port_arbiter_pkg.sv
// Shared constants for the mesh router output side: flit ids, port indices, arbiter FSM states.
package out_port_arbiter_pkg;

    localparam logic [2:0] HEADER  = 3'b001;
    localparam logic [2:0] PAYLOAD = 3'b010;
    localparam logic [2:0] TAIL    = 3'b100;

    // Port index as used by LBDR request bits and the crossbar select.
    typedef enum logic [2:0] {
        PORT_N    = 3'd0,
        PORT_E    = 3'd1,
        PORT_W    = 3'd2,
        PORT_S    = 3'd3,
        PORT_L    = 3'd4,
        PORT_NONE = 3'd7
    } port_e;

    // LOCK_x encodes port x as (state - 1).
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOCK_N = 3'd1,
        LOCK_E = 3'd2,
        LOCK_W = 3'd3,
        LOCK_S = 3'd4,
        LOCK_L = 3'd5
    } state_e;

    // One-hot (5 bit) to port index; PORT_NONE when no bit is set.
    function automatic logic [2:0] onehot5_to_idx(input logic [4:0] oh);
        logic [2:0] idx;
        idx = PORT_NONE;
        for (int i = 4; i >= 0; i--) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/out_port_arbiter_rr_arbiter5.sv
// Combinational 5-way round-robin pick: first set request at or above ptr, wrapping mod 5.
module rr_arbiter5 (
    input  logic [4:0] req,
    input  logic [2:0] ptr,
    output logic [4:0] gnt
);

    // Scan five positions starting at ptr; the first hit wins.
    always_comb begin
        logic found;
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < 5; k++) begin
            int idx;
            idx = (int'(ptr) + k) % 5;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/out_port_arbiter.sv
// Output-port arbiter: round-robin grant among input LBDR requests, locked per packet,
// pops the winning input FIFO while the downstream buffer has credits.
module out_port_arbiter
    import out_port_arbiter_pkg::*;
#(
    parameter  int CREDITS = 4,
    localparam int CW      = $clog2(CREDITS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [4:0]    req,
    input  logic [4:0]    in_valid,
    input  logic [14:0]   in_flit_id,
    input  logic          credit_in,
    output logic [4:0]    grant,
    output logic [4:0]    read_en,
    output logic          valid_out,
    output logic [2:0]    xbar_sel,
    output logic [CW-1:0] credits
);

    state_e        state_q, state_d;
    logic [2:0]    ptr_q;
    logic [4:0]    grant_q, grant_d;
    logic [2:0]    xbar_q, xbar_d;
    logic [CW-1:0] credits_q;

    logic [4:0]    pick;
    logic [2:0]    pick_idx;
    logic          locked;
    logic [2:0]    lock_idx;
    logic [2:0]    lock_id;
    logic          fire;
    logic          release_now;

    rr_arbiter5 u_rr (
        .req (req),
        .ptr (ptr_q),
        .gnt (pick)
    );

    assign pick_idx    = onehot5_to_idx(pick);
    assign locked      = (state_q != IDLE);
    assign lock_idx    = locked ? (3'(state_q) - 3'd1) : 3'd0;
    assign lock_id     = in_flit_id[lock_idx*3 +: 3];
    assign fire        = locked && in_valid[lock_idx] && (credits_q != '0);
    assign release_now = fire && (lock_id == TAIL);

    // State, registered grant/xbar select and round-robin pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            xbar_q  <= PORT_NONE;
            ptr_q   <= PORT_N;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            xbar_q  <= xbar_d;
            if (release_now) ptr_q <= (lock_idx == 3'd4) ? 3'd0 : lock_idx + 3'd1;
        end
    end

    // Next state: IDLE takes the round-robin winner; a lock ends only on a forwarded tail.
    always_comb begin
        state_d = state_q;
        grant_d = '0;
        xbar_d  = PORT_NONE;
        if (state_q == IDLE) begin
            if (req != '0) state_d = state_e'(pick_idx + 3'd1);
        end else if (release_now) begin
            state_d = IDLE;
        end
        if (state_d != IDLE) begin
            xbar_d  = 3'(state_d) - 3'd1;
            grant_d = 5'b00001 << xbar_d;
        end
    end

    // Outputs: pop strobe and link valid follow the lock and the credit/data gate.
    always_comb begin
        read_en   = '0;
        valid_out = fire;
        if (fire) read_en[lock_idx] = 1'b1;
    end

    // Downstream credit counter, saturating at CREDITS; a pop and a return cancel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credits_q <= CW'(CREDITS);
        end else if (fire && !credit_in) begin
            credits_q <= credits_q - 1'b1;
        end else if (credit_in && !fire && (credits_q != CW'(CREDITS))) begin
            credits_q <= credits_q + 1'b1;
        end
    end

    assign grant   = grant_q;
    assign xbar_sel = xbar_q;
    assign credits = credits_q;

endmodule

// File: tb/tb_out_port_arbiter.sv
// Directed bench for out_port_arbiter (CREDITS=4).
module tb_out_port_arbiter;

    localparam logic [2:0] H = 3'b001;
    localparam logic [2:0] P = 3'b010;
    localparam logic [2:0] T = 3'b100;

    logic        clk;
    logic        rst;
    logic [4:0]  req;
    logic [4:0]  in_valid;
    logic [14:0] in_flit_id;
    logic        credit_in;
    logic [4:0]  grant;
    logic [4:0]  read_en;
    logic        valid_out;
    logic [2:0]  xbar_sel;
    logic [2:0]  credits;

    int checks = 0;
    int errors = 0;

    out_port_arbiter #(.CREDITS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .in_valid   (in_valid),
        .in_flit_id (in_flit_id),
        .credit_in  (credit_in),
        .grant      (grant),
        .read_en    (read_en),
        .valid_out  (valid_out),
        .xbar_sel   (xbar_sel),
        .credits    (credits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [14:0] id_at(input int port, input logic [2:0] id);
        logic [14:0] v;
        v = 15'(id) << (3 * port);
        return v;
    endfunction

    task automatic do_reset();
        rst        = 1'b0;
        req        = '0;
        in_valid   = '0;
        in_flit_id = '0;
        credit_in  = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    logic [4:0] rr_exp [6];

    initial begin
        rst        = 1'b0;
        req        = '0;
        in_valid   = '0;
        in_flit_id = '0;
        credit_in  = 1'b0;
        tick();

        // Reset state
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_xbar", 32'(xbar_sel), 32'h7);
        chk("rst_credits", 32'(credits), 32'd4);
        chk("rst_read_en", 32'(read_en), 32'h0);
        chk("rst_valid", 32'(valid_out), 32'h0);
        rst = 1'b1;

        // 1: single 3-flit packet from N
        req = 5'b00001; in_valid = 5'b00001; in_flit_id = id_at(0, H);
        tick();
        chk("t1_grant", 32'(grant), 32'h01);
        chk("t1_xbar", 32'(xbar_sel), 32'h0);
        req = '0;
        settle();
        chk("t1_rd_h", 32'(read_en), 32'h01);
        chk("t1_vo_h", 32'(valid_out), 32'h1);
        tick();
        in_flit_id = id_at(0, P);
        settle();
        chk("t1_rd_p", 32'(read_en), 32'h01);
        tick();
        in_flit_id = id_at(0, T);
        settle();
        chk("t1_rd_t", 32'(read_en), 32'h01);
        tick();
        chk("t1_idle_grant", 32'(grant), 32'h0);
        chk("t1_idle_xbar", 32'(xbar_sel), 32'h7);
        chk("t1_credits", 32'(credits), 32'd1);
        chk("t1_idle_rd", 32'(read_en), 32'h0);

        // 2: round robin among N, W, L with 1-flit packets
        do_reset();
        rr_exp[0] = 5'b00001; rr_exp[1] = 5'b00100; rr_exp[2] = 5'b10000;
        rr_exp[3] = 5'b00001; rr_exp[4] = 5'b00100; rr_exp[5] = 5'b10000;
        req = 5'b10101; in_valid = 5'b11111; credit_in = 1'b1;
        in_flit_id = {T, T, T, T, T};
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("t2_grant%0d", i), 32'(grant), 32'(rr_exp[i]));
            chk($sformatf("t2_rd%0d", i), 32'(read_en), 32'(rr_exp[i]));
            tick();
            chk($sformatf("t2_gap%0d", i), 32'(grant), 32'h0);
        end
        chk("t2_credits", 32'(credits), 32'd4);

        // 3: credit exhaustion on E
        do_reset();
        req = 5'b00010; in_valid = 5'b00010; in_flit_id = id_at(1, H);
        tick();
        chk("t3_grant", 32'(grant), 32'h02);
        req = '0;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk($sformatf("t3_rd%0d", i), 32'(read_en), 32'h02);
            tick();
            in_flit_id = id_at(1, P);
        end
        chk("t3_cred0", 32'(credits), 32'd0);
        chk("t3_stall_rd", 32'(read_en), 32'h0);
        chk("t3_stall_grant", 32'(grant), 32'h02);
        tick();
        chk("t3_hold_grant", 32'(grant), 32'h02);
        credit_in = 1'b1;
        settle();
        chk("t3_cin_rd", 32'(read_en), 32'h0);
        tick();
        credit_in = 1'b0;
        chk("t3_cred1", 32'(credits), 32'd1);
        settle();
        chk("t3_extra_rd", 32'(read_en), 32'h02);
        tick();
        chk("t3_cred_end", 32'(credits), 32'd0);
        chk("t3_end_rd", 32'(read_en), 32'h0);
        chk("t3_end_grant", 32'(grant), 32'h02);

        // 4: empty FIFO mid-packet on S, N requesting meanwhile
        do_reset();
        req = 5'b01000; in_valid = 5'b01000; in_flit_id = id_at(3, H);
        tick();
        chk("t4_grant", 32'(grant), 32'h08);
        settle();
        chk("t4_rd_h", 32'(read_en), 32'h08);
        tick();
        req = 5'b00001; in_valid = 5'b00001; in_flit_id = id_at(0, H);
        for (int i = 0; i < 5; i++) begin
            settle();
            chk($sformatf("t4_wait_rd%0d", i), 32'(read_en), 32'h0);
            tick();
            chk($sformatf("t4_wait_grant%0d", i), 32'(grant), 32'h08);
        end
        in_valid = 5'b01001; in_flit_id = id_at(0, H) | id_at(3, P);
        settle();
        chk("t4_rd_p", 32'(read_en), 32'h08);
        tick();
        in_flit_id = id_at(0, H) | id_at(3, T);
        settle();
        chk("t4_rd_t", 32'(read_en), 32'h08);
        tick();
        chk("t4_release", 32'(grant), 32'h0);
        tick();
        chk("t4_next_n", 32'(grant), 32'h01);
        chk("t4_next_xbar", 32'(xbar_sel), 32'h0);

        // 5: simultaneous pop and credit return; saturation
        do_reset();
        req = 5'b00001; in_valid = 5'b00001; in_flit_id = id_at(0, P);
        tick();
        req = '0;
        tick();
        tick();
        chk("t5_cred2", 32'(credits), 32'd2);
        credit_in = 1'b1;
        settle();
        chk("t5_fire", 32'(read_en), 32'h01);
        tick();
        chk("t5_cred_same", 32'(credits), 32'd2);
        do_reset();
        credit_in = 1'b1;
        tick();
        chk("t5_saturate", 32'(credits), 32'd4);
        credit_in = 1'b0;

        // 6: asynchronous reset while locked on W
        do_reset();
        req = 5'b00100; in_valid = 5'b00100; in_flit_id = id_at(2, P);
        tick();
        chk("t6_grant", 32'(grant), 32'h04);
        chk("t6_xbar", 32'(xbar_sel), 32'h2);
        tick();
        chk("t6_cred3", 32'(credits), 32'd3);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_async_grant", 32'(grant), 32'h0);
        chk("t6_async_xbar", 32'(xbar_sel), 32'h7);
        chk("t6_async_cred", 32'(credits), 32'd4);
        chk("t6_async_rd", 32'(read_en), 32'h0);
        rst = 1'b1;
        tick();
        chk("t6_regrant", 32'(grant), 32'h04);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
